input_conditioner: RTL and testbench

Front-end conditioning for all player and console inputs of the pong top level. It sits between the raw board switches/buttons and the pong top-level ports (paddle mv_up/mv_down, reset_button_n, reset_score_n). Every raw input is synchronised to the 25 MHz pixel clock and debounced; paddle up/down conflicts are resolved; one-cycle press pulses are generated for the two buttons.

---
 rtl/pong_pkg.sv | 23 ++
 rtl/debounce_channel.sv | 59 +++++
 rtl/input_conditioner.sv | 61 ++++++
 tb/tb_input_conditioner.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the pong input front end: default debounce time,
// channel numbering and the idle (released) level of every raw input.
package pong_pkg;

  // 10 ms at the 25 MHz pixel clock.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

  localparam int NUM_CH = 6;

  typedef enum logic [2:0] {
    CH_RUP = 3'd0,
    CH_RDN = 3'd1,
    CH_LUP = 3'd2,
    CH_LDN = 3'd3,
    CH_RST = 3'd4,
    CH_SCR = 3'd5
  } ch_e;

  // Idle level per channel, indexed by ch_e: switches rest at 0,
  // active-low buttons rest at 1.
  localparam logic [NUM_CH-1:0] IDLE_MASK = 6'b110000;

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: two-flop synchroniser, stability counter that must
// see DEBOUNCE_CYCLES consecutive disagreeing samples before the debounced
// level follows, and a registered one-cycle pulse on each debounced 1->0.
module debounce_channel #(
  parameter int   DEBOUNCE_CYCLES = 250000,
  parameter logic IDLE_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb,
  output logic fall_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any return to the debounced level restarts the count; no accumulation.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    pulse_d = deb_q & ~deb_d;
  end

  // Reset returns everything to the idle level, so a button already held at
  // reset release must debounce again before it counts as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
      deb_q   <= IDLE_LEVEL;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign deb        = deb_q;
  assign fall_pulse = pulse_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the pong board switches and buttons: six independent debounce
// channels, paddle up/down conflict resolution and button press pulses.
module input_conditioner
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_right_up,
  input  logic raw_right_down,
  input  logic raw_left_up,
  input  logic raw_left_down,
  input  logic raw_reset_button_n,
  input  logic raw_reset_score_n,
  output logic right_up,
  output logic right_down,
  output logic left_up,
  output logic left_down,
  output logic reset_button_n,
  output logic reset_score_n,
  output logic reset_press,
  output logic score_press
);

  logic [NUM_CH-1:0] raw_w;
  logic [NUM_CH-1:0] deb_w;
  logic [NUM_CH-1:0] fall_w;
  logic              unused_fall;

  assign raw_w = {raw_reset_score_n, raw_reset_button_n, raw_left_down,
                  raw_left_up, raw_right_down, raw_right_up};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_MASK[i])
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (raw_w[i]),
      .deb       (deb_w[i]),
      .fall_pulse(fall_w[i])
    );
  end

  // Falling-edge pulses of the paddle switches have no consumer.
  assign unused_fall = &{1'b0, fall_w[CH_LDN], fall_w[CH_LUP],
                         fall_w[CH_RDN], fall_w[CH_RUP]};

  // Both directions held means the paddle holds position.
  assign right_up       = deb_w[CH_RUP] & ~deb_w[CH_RDN];
  assign right_down     = deb_w[CH_RDN] & ~deb_w[CH_RUP];
  assign left_up        = deb_w[CH_LUP] & ~deb_w[CH_LDN];
  assign left_down      = deb_w[CH_LDN] & ~deb_w[CH_LUP];
  assign reset_button_n = deb_w[CH_RST];
  assign reset_score_n  = deb_w[CH_SCR];
  assign reset_press    = fall_w[CH_RST];
  assign score_press    = fall_w[CH_SCR];

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with a short debounce time. A window-based
// reference model predicts every output each cycle; directed sections also
// measure latencies and pulse counts against fixed expected numbers.
module tb_input_conditioner;

  localparam int N = 4;
  localparam logic [5:0] IDLE = 6'b110000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [5:0] raw = IDLE;

  logic right_up, right_down, left_up, left_down;
  logic reset_button_n, reset_score_n, reset_press, score_press;

  int checks = 0;
  int failures = 0;

  input_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .raw_right_up      (raw[0]),
    .raw_right_down    (raw[1]),
    .raw_left_up       (raw[2]),
    .raw_left_down     (raw[3]),
    .raw_reset_button_n(raw[4]),
    .raw_reset_score_n (raw[5]),
    .right_up          (right_up),
    .right_down        (right_down),
    .left_up           (left_up),
    .left_down         (left_down),
    .reset_button_n    (reset_button_n),
    .reset_score_n     (reset_score_n),
    .reset_press       (reset_press),
    .score_press       (score_press)
  );

  always #5 clk = ~clk;

  // Reference model: hist[c] bit j holds the raw level sampled j edges ago.
  // The debounced level flips once the N samples that have passed through
  // the two synchroniser stages all disagree with it.
  logic [N+1:0] hist[6];
  logic md[6];
  logic mp[6];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 6; c++) begin
        hist[c] = {(N+2){IDLE[c]}};
        md[c] = IDLE[c];
        mp[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 6; c++) begin
        logic all_diff;
        hist[c] = {hist[c][N:0], raw[c]};
        all_diff = 1'b1;
        for (int j = 2; j <= N + 1; j++)
          if (hist[c][j] == md[c]) all_diff = 1'b0;
        mp[c] = all_diff & md[c];
        if (all_diff) md[c] = ~md[c];
      end
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("right_up",       right_up,       md[0] & ~md[1]);
    chk("right_down",     right_down,     md[1] & ~md[0]);
    chk("left_up",        left_up,        md[2] & ~md[3]);
    chk("left_down",      left_down,      md[3] & ~md[2]);
    chk("reset_button_n", reset_button_n, md[4]);
    chk("reset_score_n",  reset_score_n,  md[5]);
    chk("reset_press",    reset_press,    mp[4]);
    chk("score_press",    score_press,    mp[5]);
  endtask

  // One clock cycle, then compare all outputs against the model.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    int lat;
    int pulses;

    // 1: power-on reset, all idle for 50 cycles.
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_right_up", right_up, 1'b0);
    chk("rst_reset_button_n", reset_button_n, 1'b1);
    chk("rst_reset_score_n", reset_score_n, 1'b1);
    chk("rst_reset_press", reset_press, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (reset_press || score_press || right_up || right_down ||
          left_up || left_down || !reset_button_n || !reset_score_n)
        pulses++;
    end
    chk_int("idle_activity", pulses, 0);

    // 2: right_up press and release latency (6 edges counting E0).
    raw[0] = 1'b1;
    lat = -1;
    for (int e = 0; e < 20; e++) begin
      step();
      if (right_up && lat < 0) lat = e + 1;
    end
    chk_int("right_up_rise_latency", lat, 6);
    raw[0] = 1'b0;
    lat = -1;
    for (int e = 0; e < 20; e++) begin
      step();
      if (!right_up && lat < 0) lat = e + 1;
    end
    chk_int("right_up_fall_latency", lat, 6);

    // 3: short glitches on left_down never get through.
    pulses = 0;
    for (int r = 0; r < 10; r++) begin
      raw[3] = 1'b1;
      for (int i = 0; i < 3; i++) begin step(); if (left_down) pulses++; end
      raw[3] = 1'b0;
      for (int i = 0; i < 3; i++) begin step(); if (left_down) pulses++; end
    end
    for (int i = 0; i < 6; i++) begin step(); if (left_down) pulses++; end
    chk_int("left_down_glitch_seen", pulses, 0);

    // 4: both right directions held -> paddle holds; drop down -> up after 6.
    raw[0] = 1'b1;
    raw[1] = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("conflict_right_up", right_up, 1'b0);
    chk("conflict_right_down", right_down, 1'b0);
    raw[1] = 1'b0;
    lat = -1;
    for (int e = 0; e < 20; e++) begin
      step();
      if (right_up && lat < 0) lat = e + 1;
    end
    chk_int("conflict_release_latency", lat, 6);
    raw[0] = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // 5: reset button press held 20 cycles, then released.
    raw[4] = 1'b0;
    lat = -1;
    pulses = 0;
    for (int e = 0; e < 20; e++) begin
      step();
      if (!reset_button_n && lat < 0) lat = e + 1;
      if (reset_press) pulses++;
    end
    chk_int("reset_button_latency", lat, 6);
    chk_int("reset_press_count", pulses, 1);
    raw[4] = 1'b1;
    pulses = 0;
    for (int e = 0; e < 15; e++) begin
      step();
      if (reset_press) pulses++;
    end
    chk("reset_button_released", reset_button_n, 1'b1);
    chk_int("reset_release_pulses", pulses, 0);

    // 6: score button held, global reset mid-debounce, re-debounce after.
    raw[5] = 1'b0;
    for (int i = 0; i < 3; i++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_reset_score_n", reset_score_n, 1'b1);
    chk("midrst_score_press", score_press, 1'b0);
    @(negedge clk);
    check_model();
    for (int i = 0; i < 2; i++) begin
      step();
      chk("inrst_score_press", score_press, 1'b0);
    end
    rst_n = 1'b1;
    lat = -1;
    pulses = 0;
    for (int e = 0; e < 20; e++) begin
      step();
      if (score_press) begin
        pulses++;
        if (lat < 0) lat = e + 1;
      end
    end
    chk_int("score_press_latency", lat, 6);
    chk_int("score_press_count", pulses, 1);
    raw[5] = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Randomised segments on all channels, checked every cycle.
    for (int s = 0; s < 300; s++) begin
      int hold;
      raw = 6'($urandom);
      hold = int'($urandom_range(1, 10));
      for (int i = 0; i < hold; i++) step();
      if (s == 150) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_model();
        rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
